break_value_generator: RTL
==========================

BREAK_VALUE_GENERATOR -- requirements
Module: break_value_generator

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NSAT, 3, literals per clause.
- MAX_CLAUSES_PER_VARIABLE, 20, maximum occurrence-list length per variable.
- MAX_CLAUSES_PER_VARIABLE_BITS, 5, width of break counts and of occurrence index k.
- NSAT_BITS, 2, width of literal index and true-count values.
- VAR_BITS, 8, variable id width; id 0 means an empty literal slot.
- CLAUSE_BITS, 10, clause id width.

REQ-002 Ports (name, direction, width, meaning), one per line. Clock is clk; reset is reset, synchronous, active-high.
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- clause_valid_i, in, 1, request valid.
- clause_ready_o, out, 1, block accepts a request.
- clause_lits_i, in, NSAT*(VAR_BITS+1), literal j in bits [j*(VAR_BITS+1) +: VAR_BITS+1], packed as {neg, var_id}.
- occ_rd_o, out, 1, occurrence memory read strobe.
- occ_addr_o, out, VAR_BITS+MAX_CLAUSES_PER_VARIABLE_BITS, address {var_id, k}.
- occ_data_i, in, 2+CLAUSE_BITS, {entry_valid, e_neg, clause_id}; valid 1 cycle after occ_rd_o.
- tc_rd_o, out, 1, true-count memory read strobe.
- tc_addr_o, out, CLAUSE_BITS, clause id.
- tc_data_i, in, NSAT_BITS, true-literal count; valid 1 cycle after tc_rd_o.
- bv_valid_o, out, 1, result valid.
- bv_ready_i, in, 1, consumer accepts the result.
- break_values_o, out, NSAT*MAX_CLAUSES_PER_VARIABLE_BITS, break count of literal j in slice j.
- break_value_valid_o, out, NSAT, bit j = 1 when literal j has var_id != 0.

Function
REQ-003 The block is the producer feeding the heuristic selector: for a chosen unsatisfied clause it computes the break value of each candidate flip.
REQ-004 clause_ready_o SHALL be 1 exactly in state IDLE. A request is accepted on a clk edge with clause_valid_i && clause_ready_o; the literals are then registered.
REQ-005 FSM states are IDLE, LIT, OCC, OCC_D, TC, TC_D, OUT.
REQ-006 Transitions:
- IDLE -> LIT on accept, with j=0.
- LIT: if var_id[j]==0, count[j]=0 and advance j; otherwise k=0, count[j]=0, go to OCC.
- OCC: occ_rd_o=1 for exactly this cycle, occ_addr_o={var_id[j],k}; next state OCC_D.
- OCC_D: capture occ_data_i. If entry_valid==0, advance j. Else if e_neg==neg[j], the literal is false and cannot break: advance k. Else go to TC.
- TC: tc_rd_o=1 for exactly this cycle, tc_addr_o=captured clause_id; next state TC_D.
- TC_D: if tc_data_i==1, increment count[j]; advance k.
- Advance k: k+1; if k+1==MAX_CLAUSES_PER_VARIABLE, advance j, else go to OCC.
- Advance j: if j==NSAT-1, go to OUT; else j+1 and go to LIT.
REQ-007 Rationale: the clause is unsatisfied, so the variable's current value equals neg[j]. An occurrence is currently true iff e_neg != neg[j]. It breaks iff it is true and its clause true-count is 1.
REQ-008 Addresses with k >= MAX_CLAUSES_PER_VARIABLE SHALL never be issued. A count cannot exceed MAX_CLAUSES_PER_VARIABLE, so no overflow handling is required.
REQ-009 OUT:
- bv_valid_o=1; break_values_o and break_value_valid_o stay stable while bv_ready_i=0.
- On bv_ready_i=1, go to IDLE in the next cycle.
- Outputs are registered, and no new request is accepted in OUT.
REQ-010 occ_rd_o and tc_rd_o SHALL never be asserted in the same cycle, and neither is asserted outside OCC or TC.
REQ-011 Latency from accept to bv_valid_o:
- 1 cycle for IDLE -> LIT, plus 1 cycle per LIT visit;
- 2 cycles per occurrence read;
- 2 additional cycles per true-count read;
- 1 cycle to enter OUT.

Reset
REQ-012 Reset SHALL force the following on the next clk edge, from any state including mid-walk and mid-OUT:
- state = IDLE;
- bv_valid_o=0, break_values_o=0, break_value_valid_o=0;
- occ_rd_o=0, tc_rd_o=0, occ_addr_o=0, tc_addr_o=0;
- all counts, j and k = 0.
REQ-013 After a reset the block SHALL have clause_ready_o=1, and any partial results SHALL be discarded.

Verification
REQ-014 Directed scenarios:
- Reset: hold reset 2 cycles, then release -> clause_ready_o=1, bv_valid_o=0, occ_rd_o=0, tc_rd_o=0.
- Mixed clause:
  - lits {1,5},{0,7},{0,0};
  - var5 list: (c3, e_neg0, tc=1), (c4, e_neg1), entry 2 invalid;
  - var7 list: (c9, e_neg1, tc=1), (c10, e_neg1, tc=2), entry 2 invalid;
  - expected: break_value_valid_o=3'b011, break_values_o={0,1,1}, tc_rd_o pulsed 3 times (c3, c9, c10), no occ read with var_id 0.
- Full list: var 2 (neg=0) has 20 entries, all e_neg=1 with tc=1 -> count 20; occ_addr_o never equals {2,20}; latency 1+1+20*4+1 plus empty-slot LIT cycles.
- Backpressure: bv_ready_i=0 for 5 cycles in OUT with clause_valid_i=1 -> outputs stable, clause_ready_o=0, request accepted only after a handshake and the return to IDLE.
- Reset mid-walk: assert reset while in TC_D -> next cycle IDLE, all outputs 0; the following request computes fresh counts with no stale increments.
- All-empty clause: lits all var_id 0 -> bv_valid_o after NSAT+2 cycles, break_value_valid_o=000, break_values_o=0, no memory reads.

Source files
------------

// File: rtl/break_value_generator.sv
// Break-value producer for the local-search selector: for each literal of an
// unsatisfied clause, counts occurrences whose clause would become unsatisfied by the flip.
module break_value_generator #(
   parameter int NSAT                          = 3,
   parameter int MAX_CLAUSES_PER_VARIABLE      = 20,
   parameter int MAX_CLAUSES_PER_VARIABLE_BITS = 5,
   parameter int NSAT_BITS                     = 2,
   parameter int VAR_BITS                      = 8,
   parameter int CLAUSE_BITS                   = 10
) (
   input  logic                                            clk,
   input  logic                                            reset,
   input  logic                                            clause_valid_i,
   output logic                                            clause_ready_o,
   input  logic [NSAT*(VAR_BITS+1)-1:0]                    clause_lits_i,
   output logic                                            occ_rd_o,
   output logic [VAR_BITS+MAX_CLAUSES_PER_VARIABLE_BITS-1:0] occ_addr_o,
   input  logic [CLAUSE_BITS+1:0]                          occ_data_i,
   output logic                                            tc_rd_o,
   output logic [CLAUSE_BITS-1:0]                          tc_addr_o,
   input  logic [NSAT_BITS-1:0]                            tc_data_i,
   output logic                                            bv_valid_o,
   input  logic                                            bv_ready_i,
   output logic [NSAT*MAX_CLAUSES_PER_VARIABLE_BITS-1:0]   break_values_o,
   output logic [NSAT-1:0]                                 break_value_valid_o
);

   localparam int LW = VAR_BITS + 1;
   localparam int MB = MAX_CLAUSES_PER_VARIABLE_BITS;

   typedef enum logic [2:0] {IDLE, LIT, OCC, OCC_D, TC, TC_D, OUT} state_t;

   state_t                 state, state_nxt;
   logic [NSAT_BITS-1:0]   j, j_nxt;
   logic [MB-1:0]          k, k_nxt;
   logic [MB:0]            k_inc;
   logic [NSAT*LW-1:0]     lits_q;
   logic [CLAUSE_BITS-1:0] cid_q;
   logic [MB-1:0]          cnt [NSAT];
   logic [NSAT-1:0]        bvv_q;
   logic [VAR_BITS-1:0]    lit_var [NSAT];
   logic                   lit_neg [NSAT];
   logic                   accept, cnt_clr, cnt_inc, cid_load, adv_j, adv_k, last_j;
   logic                   e_valid, e_neg;

   for (genvar g = 0; g < NSAT; g++) begin : g_lit
      assign lit_var[g] = lits_q[g*LW +: VAR_BITS];
      assign lit_neg[g] = lits_q[g*LW + VAR_BITS];
      assign break_values_o[g*MB +: MB] = cnt[g];
   end

   assign e_valid = occ_data_i[CLAUSE_BITS+1];
   assign e_neg   = occ_data_i[CLAUSE_BITS];
   assign accept  = (state == IDLE) && clause_valid_i;
   assign last_j  = (j == NSAT_BITS'(NSAT-1));
   assign k_inc   = {1'b0, k} + 1'b1;

   always_comb begin
      state_nxt = state;
      j_nxt     = j;
      k_nxt     = k;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      cid_load  = 1'b0;
      adv_j     = 1'b0;
      adv_k     = 1'b0;
      case (state)
         IDLE: if (clause_valid_i) begin
            state_nxt = LIT;
            j_nxt     = '0;
         end
         LIT: begin
            cnt_clr = 1'b1;
            k_nxt   = '0;
            if (lit_var[j] == '0) adv_j = 1'b1;
            else                  state_nxt = OCC;
         end
         OCC:   state_nxt = OCC_D;
         OCC_D: begin
            cid_load = 1'b1;
            // Literal is false now, so an occurrence with equal polarity is also false and cannot break
            if (!e_valid)                adv_j = 1'b1;
            else if (e_neg == lit_neg[j]) adv_k = 1'b1;
            else                          state_nxt = TC;
         end
         TC:    state_nxt = TC_D;
         TC_D: begin
            cnt_inc = (tc_data_i == NSAT_BITS'(1));
            adv_k   = 1'b1;
         end
         OUT:   if (bv_ready_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      if (adv_k) begin
         if (k_inc == (MB+1)'(MAX_CLAUSES_PER_VARIABLE)) adv_j = 1'b1;
         else begin
            k_nxt     = k_inc[MB-1:0];
            state_nxt = OCC;
         end
      end
      if (adv_j) begin
         if (last_j) state_nxt = OUT;
         else begin
            j_nxt     = j + 1'b1;
            state_nxt = LIT;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         j     <= '0;
         k     <= '0;
         bvv_q <= '0;
         for (int i = 0; i < NSAT; i++) cnt[i] <= '0;
      end else begin
         state <= state_nxt;
         j     <= j_nxt;
         k     <= k_nxt;
         if (accept) bvv_q <= '0;
         if (cnt_clr) begin
            cnt[j]   <= '0;
            bvv_q[j] <= (lit_var[j] != '0);
         end else if (cnt_inc) begin
            cnt[j] <= cnt[j] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept)   lits_q <= clause_lits_i;
      if (cid_load) cid_q  <= occ_data_i[CLAUSE_BITS-1:0];
   end

   assign clause_ready_o      = (state == IDLE);
   assign bv_valid_o          = (state == OUT);
   assign occ_rd_o            = (state == OCC);
   assign tc_rd_o             = (state == TC);
   assign occ_addr_o          = occ_rd_o ? {lit_var[j], k} : '0;
   assign tc_addr_o           = tc_rd_o ? cid_q : '0;
   assign break_value_valid_o = bvv_q;

endmodule
